mdio_responder: RTL and testbench
=================================

// Module: mdio_responder
// PURPOSE
//  Clause-22 MDIO management responder (PHY side). Decodes MDC/MDIO frames from a station
//  manager, serves reads from a 32x16 register file and applies writes to it. Lets the
//  FPGA emulate a PHY management target, and provides a loopback target for MDIO master testing.
//  MDC is asynchronous to clock; clock must be >= 4x MDC.
// PARAMETERS
//  PHY_ADDR      5'd1      responder PHY address; frames with any other PHYAD are ignored
//  PREAMBLE_MIN  32        consecutive '1' bits sampled before ST is accepted
//  PHY_ID1       16'h0022  read-only value of reg 2
//  PHY_ID2       16'h1560  read-only value of reg 3
//  REG0_RST      16'h3100  reset value of reg 0 (ANEN=1, SSL=1, DPLX=1)
// PORTS
//  clock      in   1   system clock
//  reset      in   1   synchronous, active-low
//  mdc        in   1   management clock from master (async, 2-flop synchronised)
//  mdio_in    in   1   MDIO pad input (async, 2-flop synchronised)
//  mdio_out   out  1   MDIO drive value (valid when mdio_oe=1)
//  mdio_oe    out  1   1 = responder drives MDIO pad
//  status_in  in   16  live value returned for reg 1 (read-only)
//  wr_valid   out  1   one-clock pulse: register write committed
//  wr_addr    out  5   address of committed write
//  wr_data    out  16  data of committed write
//  rd_valid   out  1   one-clock pulse: read frame address-matched, data sourcing begins
// BEHAVIOUR
//  Reset (reset=0 at clock edge): all outputs 0, mdio_oe=0, FSM=IDLE, preamble count 0,
//   reg0=REG0_RST, all other writable regs 0. Applies mid-frame: drive released next clock.
//  Edge detect: rise/fall of synchronised mdc, one-clock pulses. MDIO sampled on MDC rise;
//   mdio_out/mdio_oe updated only on MDC fall, <=3 clocks after pad-level MDC fall.
//  FSM (advances on MDC rise unless noted):
//   IDLE  : count sampled 1s (saturate at PREAMBLE_MIN); a 0 resets count. A 0 with
//           count==PREAMBLE_MIN -> ST (first ST bit).
//   ST    : next bit must be 1, else IDLE (count 0).
//   OP    : 2 bits; 01=write, 10=read; 00/11 -> IDLE.
//   PHYAD : 5 bits MSB first.  REGAD: 5 bits MSB first.
//   TA    : 2 bits. Address mismatch -> IDLE after TA, never drives. Read: first TA bit
//           Z; on MDC fall after first TA rise drive 0 (oe=1); rd_valid pulse; latch
//           read word. Write: TA bits not checked.
//   WDATA : 16 bits MSB first; after 16th bit -> commit, IDLE.
//   RDATA : drive D15..D0 on successive MDC falls; on fall after D0 rise oe=0 -> IDLE.
//  Read word latched at TA: reg 1 = status_in, reg 2 = PHY_ID1, reg 3 = PHY_ID2, else regfile.
//  Write commit: regs 1,2,3 read-only -> no update, no wr_valid. Otherwise store, wr_valid
//   pulse with wr_addr/wr_data held until next commit. Reg0 bit15 (reset) self-clears one
//   clock after commit; reg0 bit9 (ANRS) self-clears likewise.
//  Preamble counter restarts at 0 after every frame; each frame needs a full preamble.
//  Frame abort: MDC stops mid-frame -> FSM holds; only reset or resumed bits progress it.
//  Unused upper states/counter values -> IDLE, oe=0.
// TESTING
//  1 32x'1', 01 01 00001 00100 10, 0xA5C3 -> wr_valid 1 clk, wr_addr=4, wr_data=A5C3, oe never 1
//  2 then read frame 01 10 00001 00100 -> oe=1 from 2nd TA bit, bits 0,1010010111000011, oe=0 after D0
//  3 read reg 2, PHY_ADDR=1 -> 0x0022; write 0xFFFF to reg 3 -> no wr_valid, reread 0x1560
//  4 PHYAD=00010 read/write -> oe stays 0, no wr_valid/rd_valid, next valid frame served
//  5 31x'1' preamble + write -> ignored; 32x'1' + write reg0 0x8000 -> bit15 reads back 0
//  6 reset=0 during RDATA bit 7 -> oe=0 next clock, reg0=0x3100, next full frame works

Source files
------------

// File: rtl/mdio_responder_if.sv
// mdio_responder_if: MDIO pad-side bundle between station manager and responder
interface mdio_responder_if;
  logic mdc;
  logic mdio_in;
  logic mdio_out;
  logic mdio_oe;
  modport master (output mdc, mdio_in, input mdio_out, mdio_oe);
  modport slave (input mdc, mdio_in, output mdio_out, mdio_oe);
endinterface

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO management target backed by a 32x16 register file
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter int PREAMBLE_MIN = 32,
  parameter logic [15:0] PHY_ID1 = 16'h0022,
  parameter logic [15:0] PHY_ID2 = 16'h1560,
  parameter logic [15:0] REG0_RST = 16'h3100
) (
  input logic clock,
  input logic reset,
  mdio_responder_if.slave mdio,
  input logic [15:0] status_in,
  output logic wr_valid,
  output logic [4:0] wr_addr,
  output logic [15:0] wr_data,
  output logic rd_valid
);
  localparam logic [5:0] PRE_MAX = 6'(PREAMBLE_MIN);
  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA} state_t;
  state_t state, state_n;
  logic [2:0] mdc_s;
  logic [1:0] mdio_s;
  logic rise, fall, bit_in, match, is_read, read_only;
  logic [5:0] pre_cnt;
  logic [4:0] bit_cnt;
  logic [1:0] op;
  logic [4:0] phy, regad;
  logic [15:0] shreg, wd_n, rd_word;
  logic [15:0] regs [32];
  assign rise = mdc_s[1] & ~mdc_s[2];
  assign fall = ~mdc_s[1] & mdc_s[2];
  assign bit_in = mdio_s[1];
  assign match = phy == PHY_ADDR;
  assign is_read = op == 2'b10;
  assign read_only = regad inside {[5'd1:5'd3]};
  assign wd_n = {shreg[14:0], bit_in};
  assign rd_word = regad == 5'd1 ? status_in : regad == 5'd2 ? PHY_ID1 : regad == 5'd3 ? PHY_ID2 : regs[regad];
  // two-flop synchronisers; the third MDC stage feeds edge detection
  always_ff @(posedge clock)
    if (!reset) begin
      mdc_s <= '0;
      mdio_s <= '0;
    end else begin
      mdc_s <= {mdc_s[1:0], mdio.mdc};
      mdio_s <= {mdio_s[0], mdio.mdio_in};
    end
  // frame state register
  always_ff @(posedge clock)
    if (!reset) state <= IDLE;
    else state <= state_n;
  // frame sequencing: bit-serial fields advance on MDC rise, read data ends on MDC fall
  always_comb begin
    state_n = state;
    if (rise)
      case (state)
        IDLE: state_n = !bit_in && pre_cnt == PRE_MAX ? ST : IDLE;
        ST: state_n = bit_in ? OP : IDLE;
        OP: state_n = !bit_cnt[0] ? OP : (op[0] ^ bit_in) ? PHYAD : IDLE;
        PHYAD: state_n = bit_cnt == 5'd4 ? REGAD : PHYAD;
        REGAD: state_n = bit_cnt == 5'd4 ? TA : REGAD;
        TA: state_n = bit_cnt == 5'd0 ? TA : !match ? IDLE : is_read ? RDATA : WDATA;
        WDATA: state_n = bit_cnt == 5'd15 ? IDLE : WDATA;
        RDATA: state_n = RDATA;
        default: state_n = IDLE;
      endcase
    if (fall && state == RDATA && bit_cnt >= 5'd16) state_n = IDLE;
  end
  // field capture, register file, pad drive and strobes
  always_ff @(posedge clock)
    if (!reset) begin
      pre_cnt <= '0;
      bit_cnt <= '0;
      op <= '0;
      phy <= '0;
      regad <= '0;
      shreg <= '0;
      mdio.mdio_out <= 1'b0;
      mdio.mdio_oe <= 1'b0;
      wr_valid <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      rd_valid <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= i == 0 ? REG0_RST : '0;
    end else begin
      wr_valid <= 1'b0;
      rd_valid <= 1'b0;
      regs[0][15] <= 1'b0;
      regs[0][9] <= 1'b0;
      pre_cnt <= state != IDLE ? '0 : !rise ? pre_cnt : !bit_in ? '0 : pre_cnt >= PRE_MAX ? PRE_MAX : pre_cnt + 6'd1;
      bit_cnt <= state_n != state ? '0 : (rise && state != RDATA) || (fall && state == RDATA) ? bit_cnt + 5'd1 : bit_cnt;
      if (rise) begin
        if (state == OP) op <= {op[0], bit_in};
        if (state == PHYAD) phy <= {phy[3:0], bit_in};
        if (state == REGAD) regad <= {regad[3:0], bit_in};
        if (state == WDATA) shreg <= wd_n;
        if (state == WDATA && bit_cnt == 5'd15 && !read_only) begin
          regs[regad] <= wd_n;
          wr_valid <= 1'b1;
          wr_addr <= regad;
          wr_data <= wd_n;
        end
      end
      if (fall && state == TA && bit_cnt == 5'd1 && match && is_read) begin
        mdio.mdio_oe <= 1'b1;
        mdio.mdio_out <= 1'b0;
        rd_valid <= 1'b1;
        shreg <= rd_word;
      end
      if (fall && state == RDATA) begin
        mdio.mdio_oe <= bit_cnt < 5'd16;
        mdio.mdio_out <= (bit_cnt < 5'd16) & shreg[15];
        shreg <= {shreg[14:0], 1'b0};
      end
      if (fall && state != TA && state != RDATA) begin
        mdio.mdio_oe <= 1'b0;
        mdio.mdio_out <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: randomized MDIO frames checked against a register-file model
module tb_mdio_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [15:0] status_in = '0;
  logic wr_valid, rd_valid;
  logic [4:0] wr_addr;
  logic [15:0] wr_data;
  logic m_drv = 1'b1;
  int pass_n = 0, total_n = 0, wr_pulses = 0, rd_pulses = 0;
  logic [15:0] model [32];
  mdio_responder_if bus();
  assign bus.mdio_in = bus.mdio_oe ? bus.mdio_out : m_drv;
  mdio_responder dut (.clock(clock), .reset(reset), .mdio(bus), .status_in(status_in),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_valid(rd_valid));
  always #5 clock = ~clock;
  always @(negedge clock) begin
    if (wr_valid) wr_pulses++;
    if (rd_valid) rd_pulses++;
  end
  function automatic logic [15:0] exp_read(input logic [4:0] ra);
    return ra == 5'd1 ? status_in : ra == 5'd2 ? 16'h0022 : ra == 5'd3 ? 16'h1560 : model[ra];
  endfunction
  task automatic model_write(input logic [4:0] ra, input logic [15:0] d);
    if (ra == 5'd0) model[0] = d & ~16'h8200;
    else if (ra > 5'd3) model[ra] = d;
  endtask
  task automatic model_reset;
    foreach (model[i]) model[i] = '0;
    model[0] = 16'h3100;
  endtask
  task automatic send_bit(input logic b, output logic oe_s, output logic out_s);
    bus.mdc = 1'b0;
    m_drv = b;
    #40;
    oe_s = bus.mdio_oe;
    out_s = bus.mdio_out;
    #10;
    bus.mdc = 1'b1;
    #50;
  endtask
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] wd, output logic [16:0] rd, output int oe_n);
    logic [31:0] body;
    logic o, d;
    body = {2'b01, op, phy, ra, op == 2'b10 ? 18'h3FFFF : {2'b10, wd}};
    oe_n = 0;
    rd = '0;
    for (int i = 0; i < pre; i++) begin send_bit(1'b1, o, d); oe_n += int'(o); end
    for (int i = 31; i >= 0; i--) begin
      send_bit(body[i], o, d);
      oe_n += int'(o);
      if (i <= 16) rd[i] = d;
    end
    send_bit(1'b0, o, d);
    oe_n += int'(o);
  endtask
  task automatic test_reset;
    logic [16:0] rd;
    int oe_n;
    reset = 1'b0;
    bus.mdc = 1'b0;
    repeat (3) @(negedge clock);
    model_reset();
    total_n++; if ({bus.mdio_oe, bus.mdio_out, wr_valid, rd_valid, wr_addr, wr_data} !== 25'd0) $display("FAIL reset_outputs: got %h required 0", {bus.mdio_oe, bus.mdio_out, wr_valid, rd_valid, wr_addr, wr_data}); else pass_n++;
    reset = 1'b1;
    @(negedge clock);
    frame(32, 2'b10, 5'd1, 5'd0, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, 16'h3100}) $display("FAIL reset_reg0: got %h required %h", rd, {1'b0, 16'h3100}); else pass_n++;
    total_n++; if (oe_n !== 17) $display("FAIL reset_read_oe: got %0d required 17", oe_n); else pass_n++;
  endtask
  task automatic test_write_read;
    logic [16:0] rd;
    int oe_n, w0, r0;
    w0 = wr_pulses;
    frame(32, 2'b01, 5'd1, 5'd4, 16'hA5C3, rd, oe_n);
    model_write(5'd4, 16'hA5C3);
    total_n++; if (wr_pulses - w0 !== 1) $display("FAIL wr_pulse: got %0d required 1", wr_pulses - w0); else pass_n++;
    total_n++; if ({wr_addr, wr_data} !== {5'd4, 16'hA5C3}) $display("FAIL wr_addr_data: got %h/%h required 4/a5c3", wr_addr, wr_data); else pass_n++;
    total_n++; if (oe_n !== 0) $display("FAIL write_oe: got %0d required 0", oe_n); else pass_n++;
    r0 = rd_pulses;
    frame(32, 2'b10, 5'd1, 5'd4, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[4]}) $display("FAIL read_back: got %h required %h", rd, {1'b0, model[4]}); else pass_n++;
    total_n++; if (oe_n !== 17) $display("FAIL read_oe: got %0d required 17", oe_n); else pass_n++;
    total_n++; if (rd_pulses - r0 !== 1) $display("FAIL rd_pulse: got %0d required 1", rd_pulses - r0); else pass_n++;
  endtask
  task automatic test_readonly;
    logic [16:0] rd;
    int oe_n, w0;
    status_in = 16'($urandom);
    frame(32, 2'b10, 5'd1, 5'd1, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, exp_read(5'd1)}) $display("FAIL status_read: got %h required %h", rd, {1'b0, exp_read(5'd1)}); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd2, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, 16'h0022}) $display("FAIL id1_read: got %h required 00022", rd); else pass_n++;
    w0 = wr_pulses;
    frame(32, 2'b01, 5'd1, 5'd3, 16'hFFFF, rd, oe_n);
    total_n++; if (wr_pulses !== w0) $display("FAIL ro_write_pulse: got %0d required 0", wr_pulses - w0); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd3, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, 16'h1560}) $display("FAIL id2_read: got %h required 01560", rd); else pass_n++;
  endtask
  task automatic test_phyad_mismatch;
    logic [16:0] rd;
    int oe_n, w0, r0;
    r0 = rd_pulses;
    frame(32, 2'b10, 5'd2, 5'd4, '0, rd, oe_n);
    total_n++; if (oe_n !== 0 || rd_pulses !== r0) $display("FAIL foreign_read: oe %0d rd_valid %0d required 0/0", oe_n, rd_pulses - r0); else pass_n++;
    w0 = wr_pulses;
    frame(32, 2'b01, 5'd2, 5'd6, 16'($urandom), rd, oe_n);
    total_n++; if (oe_n !== 0 || wr_pulses !== w0) $display("FAIL foreign_write: oe %0d wr_valid %0d required 0/0", oe_n, wr_pulses - w0); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd6, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[6]} || oe_n !== 17) $display("FAIL after_foreign: got %h oe %0d required %h oe 17", rd, oe_n, {1'b0, model[6]}); else pass_n++;
  endtask
  task automatic test_preamble;
    logic [16:0] rd;
    int oe_n, w0;
    w0 = wr_pulses;
    frame(31, 2'b01, 5'd1, 5'd5, 16'h1234, rd, oe_n);
    total_n++; if (wr_pulses !== w0) $display("FAIL short_preamble: got %0d writes required 0", wr_pulses - w0); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd5, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[5]}) $display("FAIL short_preamble_reg: got %h required %h", rd, {1'b0, model[5]}); else pass_n++;
    w0 = wr_pulses;
    frame(32, 2'b01, 5'd1, 5'd0, 16'h8000, rd, oe_n);
    model_write(5'd0, 16'h8000);
    total_n++; if (wr_pulses - w0 !== 1 || wr_data !== 16'h8000) $display("FAIL reg0_write: pulses %0d data %h required 1/8000", wr_pulses - w0, wr_data); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd0, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[0]}) $display("FAIL reg0_selfclear: got %h required %h", rd, {1'b0, model[0]}); else pass_n++;
    frame(32, 2'b01, 5'd1, 5'd0, 16'h1340, rd, oe_n);
    model_write(5'd0, 16'h1340);
    frame(32, 2'b10, 5'd1, 5'd0, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[0]}) $display("FAIL anrs_selfclear: got %h required %h", rd, {1'b0, model[0]}); else pass_n++;
  endtask
  task automatic test_random;
    logic [16:0] rd;
    logic [4:0] ra, phy;
    logic [15:0] d;
    logic rd_op;
    int oe_n, w0, pre;
    for (int n = 0; n < 16; n++) begin
      ra = 5'($urandom_range(0, 31));
      phy = $urandom_range(0, 3) == 0 ? 5'($urandom) : 5'd1;
      d = 16'($urandom);
      rd_op = 1'($urandom);
      pre = 32 + $urandom_range(0, 4);
      status_in = 16'($urandom);
      w0 = wr_pulses;
      frame(pre, rd_op ? 2'b10 : 2'b01, phy, ra, d, rd, oe_n);
      if (rd_op) begin
        total_n++; if (oe_n !== (phy == 5'd1 ? 17 : 0) || (phy == 5'd1 && rd !== {1'b0, exp_read(ra)})) $display("FAIL rand_read %0d: reg %0d phy %0d got %h oe %0d required %h", n, ra, phy, rd, oe_n, {1'b0, exp_read(ra)}); else pass_n++;
      end else begin
        total_n++; if (wr_pulses - w0 !== int'(phy == 5'd1 && (ra == 5'd0 || ra > 5'd3))) $display("FAIL rand_write %0d: reg %0d phy %0d got %0d pulses", n, ra, phy, wr_pulses - w0); else pass_n++;
        if (phy == 5'd1) model_write(ra, d);
      end
    end
  endtask
  task automatic test_reset_midframe;
    logic [16:0] rd;
    logic [31:0] body;
    logic o, dd;
    int oe_n;
    frame(32, 2'b01, 5'd1, 5'd4, 16'h5A5A, rd, oe_n);
    frame(32, 2'b01, 5'd1, 5'd0, 16'h1F1F, rd, oe_n);
    body = {2'b01, 2'b10, 5'd1, 5'd0, 18'h3FFFF};
    for (int i = 0; i < 32; i++) send_bit(1'b1, o, dd);
    for (int i = 31; i >= 8; i--) send_bit(body[i], o, dd);
    bus.mdc = 1'b0;
    m_drv = 1'b1;
    #40;
    total_n++; if (bus.mdio_oe !== 1'b1) $display("FAIL midframe_driving: got %b required 1", bus.mdio_oe); else pass_n++;
    reset = 1'b0;
    #10;
    total_n++; if (bus.mdio_oe !== 1'b0) $display("FAIL midframe_release: got %b required 0", bus.mdio_oe); else pass_n++;
    #20;
    reset = 1'b1;
    model_reset();
    #50;
    frame(32, 2'b10, 5'd1, 5'd0, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, 16'h3100} || oe_n !== 17) $display("FAIL post_reset_reg0: got %h oe %0d required 03100 oe 17", rd, oe_n); else pass_n++;
    frame(32, 2'b10, 5'd1, 5'd4, '0, rd, oe_n);
    total_n++; if (rd !== {1'b0, model[4]}) $display("FAIL post_reset_reg4: got %h required %h", rd, {1'b0, model[4]}); else pass_n++;
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_readonly();
    test_phyad_mismatch();
    test_preamble();
    test_random();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
